// File: rtl/sobel_window_gen.sv
// 3x3 neighbourhood generator for a raster RGB332 pixel stream.
// Two line buffers supply rows r-1/r-2; the window registers present p0..p8 one clock after acceptance.
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             pix_sof,
  output logic [PIX_W-1:0] p0,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic [PIX_W-1:0] p3,
  output logic [PIX_W-1:0] p4,
  output logic [PIX_W-1:0] p5,
  output logic [PIX_W-1:0] p6,
  output logic [PIX_W-1:0] p7,
  output logic [PIX_W-1:0] p8,
  output logic             win_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {WAIT_SOF, FILL, STREAM} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d, cur_col;
  logic [RW-1:0]    row_q, row_d, cur_row;
  logic             take;
  logic             last;
  logic [PIX_W-1:0] win_q [9];
  logic [PIX_W-1:0] win_d [9];
  logic             win_valid_q, win_valid_d;
  logic             frame_done_q, frame_done_d;

  logic [PIX_W-1:0] lb1_mem [IMG_WIDTH];
  logic [PIX_W-1:0] lb2_mem [IMG_WIDTH];
  logic [PIX_W-1:0] lb1_rd_q, lb2_rd_q;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    cur_col      = col_q;
    cur_row      = row_q;
    take         = 1'b0;
    last         = 1'b0;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    // A start-of-frame pixel always restarts at (0,0), even mid-frame.
    if (pix_valid) begin
      if (pix_sof) begin
        take    = 1'b1;
        cur_col = '0;
        cur_row = '0;
      end else if (state_q != WAIT_SOF) begin
        take = 1'b1;
      end
    end

    if (take) begin
      last = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
      if (last) begin
        state_d = WAIT_SOF;
        col_d   = '0;
        row_d   = '0;
      end else if (cur_row >= RW'(2)) begin
        state_d = STREAM;
      end else begin
        state_d = FILL;
      end

      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb2_rd_q;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb1_rd_q;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix_in;

      win_valid_d  = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      frame_done_d = win_valid_d && last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_SOF;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // Read is prefetched for the next column so the registered RAM output is ready at the next acceptance.
  always_ff @(posedge clk) begin
    if (take) begin
      lb1_mem[cur_col] <= pix_in;
      lb2_mem[cur_col] <= lb1_rd_q;
      lb1_rd_q         <= lb1_mem[col_d];
      lb2_rd_q         <= lb2_mem[col_d];
    end
  end

  assign p0         = win_q[0];
  assign p1         = win_q[1];
  assign p2         = win_q[2];
  assign p3         = win_q[3];
  assign p4         = win_q[4];
  assign p5         = win_q[5];
  assign p6         = win_q[6];
  assign p7         = win_q[7];
  assign p8         = win_q[8];
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == FILL) || (state_q == STREAM);

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on an 8x6 frame: stimulus pushes expected windows,
// a negedge monitor pops and compares whenever win_valid is seen.
module tb_sobel_window_gen;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       pix_sof;
  logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic       win_valid, frame_done, busy;

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
    .win_valid(win_valid), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int win_cnt = 0;
  int fd_cnt = 0;
  logic [79:0] exp_q[$];
  logic [79:0] log_w [512];
  logic [7:0]  img [H][W];
  logic        pv_prev = 1'b0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  always @(posedge clk) pv_prev <= pix_valid;

  // Monitor: every presented window must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [79:0] act;
    if (rst_n && (win_valid || frame_done)) begin
      act = {7'b0, frame_done, p0, p1, p2, p3, p4, p5, p6, p7, p8};
      check("win_needs_accept", {79'b0, pv_prev}, 80'd1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_window: got %h required none", act);
      end else begin
        check("window", act, exp_q.pop_front());
      end
      if (win_cnt < 512) log_w[win_cnt] = act;
      win_cnt++;
      if (frame_done) fd_cnt++;
    end
  end

  task automatic send(input int r, input int c, input logic [7:0] v, input bit sof, input bit expect_win);
    logic [79:0] e;
    @(posedge clk);
    #1;
    pix_in    = v;
    pix_valid = 1'b1;
    pix_sof   = sof;
    if (expect_win) begin
      img[r][c] = v;
      if (r >= 2 && c >= 2) begin
        e = {7'b0, (r == H-1 && c == W-1),
             img[r-2][c-2], img[r-2][c-1], img[r-2][c],
             img[r-1][c-2], img[r-1][c-1], img[r-1][c],
             img[r][c-2],   img[r][c-1],   img[r][c]};
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      pix_in    = 8'($urandom);
    end
  endtask

  task automatic frame(input logic [7:0] mask, input bit gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(r, c, 8'(r*16 + c) ^ mask, (r == 0 && c == 0), 1'b1);
        if (gaps) idle(3);
      end
  endtask

  localparam logic [79:0] FIRST_WIN =
    {8'h00, 8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};

  initial begin
    int s, f;
    rst_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {5'b0, win_valid, frame_done, busy, p0, p1, p2, p3, p4, p5, p6, p7, p8}, 80'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous frame.
    s = win_cnt; f = fd_cnt;
    frame(8'h00, 1'b0);
    idle(4);
    check("t1_win_count", 80'(win_cnt - s), 80'd24);
    check("t1_fd_count", 80'(fd_cnt - f), 80'd1);
    check("t1_first_win", log_w[s], FIRST_WIN);
    check("t1_last_p8_fd", {71'b0, log_w[s+23][72], log_w[s+23][7:0]}, {71'b0, 1'b1, 8'h57});
    check("t1_busy_after", {79'b0, busy}, 80'd0);

    // Same frame with idle gaps.
    s = win_cnt; f = fd_cnt;
    frame(8'h00, 1'b1);
    idle(4);
    check("t2_win_count", 80'(win_cnt - s), 80'd24);
    check("t2_fd_count", 80'(fd_cnt - f), 80'd1);
    check("t2_first_win", log_w[s], FIRST_WIN);

    // Leading pixels without start-of-frame are discarded.
    for (int i = 0; i < 5; i++) send(0, 0, 8'hA0 + 8'(i), 1'b0, 1'b0);
    s = win_cnt; f = fd_cnt;
    frame(8'h00, 1'b0);
    idle(4);
    check("t3_win_count", 80'(win_cnt - s), 80'd24);
    check("t3_first_p0_p8", {64'b0, log_w[s][71:64], log_w[s][7:0]}, {64'b0, 8'h00, 8'h22});

    // Abort at (3,4) by a new start-of-frame, then a full frame.
    s = win_cnt; f = fd_cnt;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r < 3 || (r == 3 && c < 4)) send(r, c, 8'(r*16 + c), (r == 0 && c == 0), 1'b1);
    frame(8'h00, 1'b0);
    idle(4);
    check("t4_win_count", 80'(win_cnt - s), 80'd32);
    check("t4_fd_count", 80'(fd_cnt - f), 80'd1);
    check("t4_new_first_win", log_w[s+8], FIRST_WIN);

    // Asynchronous reset mid-frame; rest of the frame must be ignored.
    s = win_cnt;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r < 4 || (r == 4 && c < 5)) send(r, c, 8'(r*16 + c), (r == 0 && c == 0), 1'b1);
    idle(1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_reset_outputs", {5'b0, win_valid, frame_done, busy, p0, p1, p2, p3, p4, p5, p6, p7, p8}, 80'd0);
    check("t5_drained", 80'(exp_q.size()), 80'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    s = win_cnt;
    for (int r = 4; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r > 4 || c >= 5) send(r, c, 8'(r*16 + c), 1'b0, 1'b0);
    idle(4);
    check("t5_ignored_windows", 80'(win_cnt - s), 80'd0);
    check("t5_busy_after", {79'b0, busy}, 80'd0);

    // Two back-to-back frames, the second inverted.
    s = win_cnt; f = fd_cnt;
    frame(8'h00, 1'b0);
    frame(8'hFF, 1'b0);
    idle(4);
    check("t6_win_count", 80'(win_cnt - s), 80'd48);
    check("t6_fd_count", 80'(fd_cnt - f), 80'd2);
    check("t6_second_p0_p8", {64'b0, log_w[s+24][71:64], log_w[s+24][7:0]}, {64'b0, 8'hFF, 8'hDD});

    check("final_queue_empty", 80'(exp_q.size()), 80'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
